cdf_read_arbiter: RTL and testbench

//  Shares the single read port of the CDF lookup SRAM (16-bit address, 128-bit read bus) between
//  two requesters: requester 0 is the output-pipeline CDF fetch stage, requester 1 is the CDF

---
 rtl/cdf_read_arbiter.sv | 119 +++++++++++
 tb/tb_cdf_read_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdf_read_arbiter.sv
// cdf_read_arbiter
//   Shares the single read port of the CDF lookup SRAM between two requesters:
//   requester 0 (output-pipeline CDF fetch) and requester 1 (CDF build/normalise).
//   At most one read is granted per cycle. Each granted read is tracked through
//   the fixed SRAM latency and its data is returned to the requester that issued it.
//   In strict-priority mode a starvation guard forces a requester-1 grant after
//   MAX_WAIT consecutive refused cycles.
//
// Ports
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   Prio0                 1 = strict priority to req0 (guarded), 0 = round-robin
//   Req0/Req1             level read requests, held until granted
//   Addr0/Addr1           read addresses, sampled only in the grant cycle
//   Gnt0/Gnt1             combinational grants
//   Valid0/Valid1         registered one-cycle return strobes
//   Data0/Data1           registered return data (holds between returns)
//   ReadEnable            SRAM read strobe
//   ReadAddress           SRAM read address (0 when idle)
//   ReadBus               SRAM read data, RD_LAT cycles after ReadEnable
//   Starved               registered one-cycle pulse after a forced req1 grant
module cdf_read_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 128,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              Prio0,
  input  logic              Req0,
  input  logic [ADDR_W-1:0] Addr0,
  output logic              Gnt0,
  output logic              Valid0,
  output logic [DATA_W-1:0] Data0,
  input  logic              Req1,
  input  logic [ADDR_W-1:0] Addr1,
  output logic              Gnt1,
  output logic              Valid1,
  output logic [DATA_W-1:0] Data1,
  output logic              ReadEnable,
  output logic [ADDR_W-1:0] ReadAddress,
  input  logic [DATA_W-1:0] ReadBus,
  output logic              Starved
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;
  logic              rr_last;
  logic              forced;
  // Latency pipe: bit 0 is the newest stage, bit RD_LAT-1 the output stage.
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_id;

  always_comb begin
    Gnt0   = 1'b0;
    Gnt1   = 1'b0;
    forced = 1'b0;
    if (reset_n) begin
      if (Req0 && Req1) begin
        if (Prio0) begin
          forced = (wait_cnt == WAIT_MAX);
          Gnt1   = forced;
          Gnt0   = !forced;
        end else begin
          // rr_last names the previous winner; the other requester wins the tie.
          Gnt0 = rr_last;
          Gnt1 = !rr_last;
        end
      end else begin
        Gnt0 = Req0;
        Gnt1 = Req1;
      end
    end
  end

  always_comb begin
    ReadEnable  = Gnt0 | Gnt1;
    ReadAddress = '0;
    if (Gnt0)      ReadAddress = Addr0;
    else if (Gnt1) ReadAddress = Addr1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      Valid0   <= 1'b0;
      Valid1   <= 1'b0;
      Data0    <= '0;
      Data1    <= '0;
      Starved  <= 1'b0;
      rr_last  <= 1'b1;
      wait_cnt <= '0;
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else begin
      Starved <= forced;
      if (ReadEnable) rr_last <= Gnt1;

      // Counts in both modes so switching to strict priority sees the true wait.
      if (Req1 && !Gnt1) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      pipe_vld <= (pipe_vld << 1) | RD_LAT'(ReadEnable);
      pipe_id  <= (pipe_id << 1)  | RD_LAT'(Gnt1);

      Valid0 <= pipe_vld[RD_LAT-1] && !pipe_id[RD_LAT-1];
      Valid1 <= pipe_vld[RD_LAT-1] &&  pipe_id[RD_LAT-1];
      if (pipe_vld[RD_LAT-1]) begin
        if (pipe_id[RD_LAT-1]) Data1 <= ReadBus;
        else                   Data0 <= ReadBus;
      end
    end
  end

endmodule

// File: tb/tb_cdf_read_arbiter.sv
// Bench for cdf_read_arbiter: two instances (RD_LAT=1 and RD_LAT=3) share the
// request inputs; a transaction-level model predicts grants and tagged returns.
module tb_cdf_read_arbiter;

  localparam int MAX_WAIT = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         Prio0 = 1'b0;
  logic         Req0 = 1'b0, Req1 = 1'b0;
  logic [15:0]  Addr0 = '0, Addr1 = '0;

  logic         a_g0, a_g1, a_v0, a_v1, a_re, a_st;
  logic [127:0] a_d0, a_d1, a_bus;
  logic [15:0]  a_raddr;
  logic         b_g0, b_g1, b_v0, b_v1, b_re, b_st;
  logic [127:0] b_d0, b_d1, b_bus;
  logic [15:0]  b_raddr;
  logic [127:0] b_pipe [3];

  always #5 clock = ~clock;

  cdf_read_arbiter #(.ADDR_W(16), .DATA_W(128), .RD_LAT(1), .MAX_WAIT(MAX_WAIT)) dut1 (
    .clock(clock), .reset_n(reset_n), .Prio0(Prio0),
    .Req0(Req0), .Addr0(Addr0), .Gnt0(a_g0), .Valid0(a_v0), .Data0(a_d0),
    .Req1(Req1), .Addr1(Addr1), .Gnt1(a_g1), .Valid1(a_v1), .Data1(a_d1),
    .ReadEnable(a_re), .ReadAddress(a_raddr), .ReadBus(a_bus), .Starved(a_st));

  cdf_read_arbiter #(.ADDR_W(16), .DATA_W(128), .RD_LAT(3), .MAX_WAIT(MAX_WAIT)) dut3 (
    .clock(clock), .reset_n(reset_n), .Prio0(Prio0),
    .Req0(Req0), .Addr0(Addr0), .Gnt0(b_g0), .Valid0(b_v0), .Data0(b_d0),
    .Req1(Req1), .Addr1(Addr1), .Gnt1(b_g1), .Valid1(b_v1), .Data1(b_d1),
    .ReadEnable(b_re), .ReadAddress(b_raddr), .ReadBus(b_bus), .Starved(b_st));

  // SRAM contents as a fixed function of the address.
  function automatic logic [127:0] mem(input logic [15:0] a);
    logic [15:0] sw;
    sw = {a[7:0], a[15:8]};
    return {a ^ 16'h5A5A, a * 16'd3, ~a, a + 16'd7, {8'h00, a[7:0]}, a, 16'hC3C3 ^ sw, a * a};
  endfunction

  // SRAM models; bus carries junk whenever no read is landing.
  always @(posedge clock) begin
    a_bus     <= a_re ? mem(a_raddr) : {$urandom, $urandom, $urandom, $urandom};
    b_pipe[0] <= b_re ? mem(b_raddr) : {$urandom, $urandom, $urandom, $urandom};
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_bus = b_pipe[2];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  typedef struct { int due; logic id; logic [127:0] data; } ret_t;
  ret_t qa[$];
  ret_t qb[$];
  int   m_wait = 0;
  logic m_last = 1'b1, m_starve = 1'b0, m_forced = 1'b0;
  logic e_g0, e_g1, e_re;
  logic [15:0]  e_addr;
  logic e_v0a, e_v1a, e_v0b, e_v1b;
  logic [127:0] e_d0a = '0, e_d1a = '0, e_d0b = '0, e_d1b = '0;
  logic [39:0]  exp_ctl;
  logic [257:0] exp_a, exp_b;
  bit   pend = 0;

  int n_vec = 0, n_err = 0;

  wire [39:0]  obs_ctl = {a_g0, a_g1, a_re, a_raddr, a_st, b_g0, b_g1, b_re, b_raddr, b_st};
  wire [257:0] obs_a   = {a_v0, a_v1, a_d0, a_d1};
  wire [257:0] obs_b   = {b_v0, b_v1, b_d0, b_d1};

  task automatic model_eval();
    ret_t r;
    e_g0 = 1'b0; e_g1 = 1'b0; m_forced = 1'b0;
    if (reset_n) begin
      if (Req0 && Req1) begin
        if (Prio0) begin
          if (m_wait == MAX_WAIT) begin e_g1 = 1'b1; m_forced = 1'b1; end
          else e_g0 = 1'b1;
        end else if (m_last) e_g0 = 1'b1;
        else e_g1 = 1'b1;
      end else begin
        e_g0 = Req0; e_g1 = Req1;
      end
    end
    e_re   = e_g0 | e_g1;
    e_addr = e_g0 ? Addr0 : (e_g1 ? Addr1 : 16'h0000);
    e_v0a = 1'b0; e_v1a = 1'b0; e_v0b = 1'b0; e_v1b = 1'b0;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      r = qa.pop_front();
      if (r.id) begin e_v1a = 1'b1; e_d1a = r.data; end
      else      begin e_v0a = 1'b1; e_d0a = r.data; end
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      r = qb.pop_front();
      if (r.id) begin e_v1b = 1'b1; e_d1b = r.data; end
      else      begin e_v0b = 1'b1; e_d0b = r.data; end
    end
    exp_ctl = {2{e_g0, e_g1, e_re, e_addr, m_starve}};
    exp_a   = {e_v0a, e_v1a, e_d0a, e_d1a};
    exp_b   = {e_v0b, e_v1b, e_d0b, e_d1b};
    pend = 1;
  endtask

  task automatic model_commit();
    ret_t r;
    if (!pend) return;
    pend = 0;
    if (!reset_n) begin
      m_wait = 0; m_last = 1'b1; m_starve = 1'b0;
      qa.delete(); qb.delete();
      e_d0a = '0; e_d1a = '0; e_d0b = '0; e_d1b = '0;
    end else begin
      m_starve = m_forced;
      if (e_re) m_last = e_g1;
      if (Req1 && !e_g1) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else m_wait = 0;
      if (e_re) begin
        r.id = e_g1; r.data = mem(e_addr);
        r.due = cyc + 2; qa.push_back(r);
        r.due = cyc + 4; qb.push_back(r);
      end
    end
  endtask

  // Applies one cycle of inputs and evaluates the model at the sampling point.
  task automatic drive(input logic rn, input logic p, input logic r0, input logic [15:0] a0,
                       input logic r1, input logic [15:0] a1);
    model_commit();
    @(posedge clock);
    #1;
    reset_n = rn; Prio0 = p; Req0 = r0; Addr0 = a0; Req1 = r1; Addr1 = a1;
    @(negedge clock);
    model_eval();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h5678);
      n_vec++;
      if (obs_ctl !== exp_ctl) begin n_err++; $display("FAIL reset_ctl cyc=%0d got=%h want=%h", cyc, obs_ctl, exp_ctl); end
      n_vec++;
      if ({a_g0, a_g1, a_raddr, b_g0, b_g1, b_raddr} !== 36'h0) begin
        n_err++; $display("FAIL reset_gnt cyc=%0d got=%b%b_%h want=0", cyc, a_g0, a_g1, a_raddr);
      end
      if (i >= 1) begin
        n_vec++;
        if ({a_v0, a_v1, b_v0, b_v1} !== 4'b0000) begin
          n_err++; $display("FAIL reset_valid cyc=%0d got=%b%b%b%b want=0000", cyc, a_v0, a_v1, b_v0, b_v1);
        end
        n_vec++;
        if (obs_a !== exp_a) begin n_err++; $display("FAIL reset_ret1 cyc=%0d got=%h want=%h", cyc, obs_a, exp_a); end
      end
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, (i == 0), 16'h0042, 1'b0, 16'h0000);
      n_vec++;
      if (obs_ctl !== exp_ctl) begin n_err++; $display("FAIL single_ctl cyc=%0d got=%h want=%h", cyc, obs_ctl, exp_ctl); end
      n_vec++;
      if (obs_a !== exp_a) begin n_err++; $display("FAIL single_ret1 cyc=%0d got=%h want=%h", cyc, obs_a, exp_a); end
      n_vec++;
      if (obs_b !== exp_b) begin n_err++; $display("FAIL single_ret3 cyc=%0d got=%h want=%h", cyc, obs_b, exp_b); end
      n_vec++;
      if (a_v0 !== (i == 2) || a_v1 !== 1'b0) begin
        n_err++; $display("FAIL single_valid i=%0d got=%b%b want=%b0", i, a_v0, a_v1, (i == 2));
      end
      if (i == 2) begin
        n_vec++;
        if (a_d0 !== mem(16'h0042)) begin n_err++; $display("FAIL single_data got=%h want=%h", a_d0, mem(16'h0042)); end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] x0, x1;
    x0 = 16'($urandom); x1 = 16'($urandom);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, (i < 6), x0, (i < 6), x1);
      n_vec++;
      if (obs_ctl !== exp_ctl) begin n_err++; $display("FAIL rr_ctl cyc=%0d got=%h want=%h", cyc, obs_ctl, exp_ctl); end
      n_vec++;
      if (obs_a !== exp_a) begin n_err++; $display("FAIL rr_ret1 cyc=%0d got=%h want=%h", cyc, obs_a, exp_a); end
      n_vec++;
      if (obs_b !== exp_b) begin n_err++; $display("FAIL rr_ret3 cyc=%0d got=%h want=%h", cyc, obs_b, exp_b); end
      if (i < 6) begin
        n_vec++;
        if (a_g0 !== (i % 2 == 0) || a_g1 !== (i % 2 == 1)) begin
          n_err++; $display("FAIL rr_order i=%0d got=%b%b want=%b%b", i, a_g0, a_g1, (i % 2 == 0), (i % 2 == 1));
        end
      end
    end
  endtask

  task automatic test_strict_guard();
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b1, (i < 27), 16'(16'h0100 + i), (i < 27), 16'h0BEE);
      n_vec++;
      if (obs_ctl !== exp_ctl) begin n_err++; $display("FAIL strict_ctl cyc=%0d got=%h want=%h", cyc, obs_ctl, exp_ctl); end
      n_vec++;
      if (obs_a !== exp_a) begin n_err++; $display("FAIL strict_ret1 cyc=%0d got=%h want=%h", cyc, obs_a, exp_a); end
      n_vec++;
      if (obs_b !== exp_b) begin n_err++; $display("FAIL strict_ret3 cyc=%0d got=%h want=%h", cyc, obs_b, exp_b); end
      if (i < 27) begin
        n_vec++;
        if (a_g1 !== (i % 9 == 8) || a_st !== (i % 9 == 0 && i > 0)) begin
          n_err++; $display("FAIL strict_pattern i=%0d got gnt1=%b starved=%b want %b %b",
                            i, a_g1, a_st, (i % 9 == 8), (i % 9 == 0 && i > 0));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, (i < 4), (i % 2 == 0) ? 16'h0010 : 16'h0020, 1'b0, 16'h0000);
      n_vec++;
      if (obs_ctl !== exp_ctl) begin n_err++; $display("FAIL b2b_ctl cyc=%0d got=%h want=%h", cyc, obs_ctl, exp_ctl); end
      n_vec++;
      if (obs_a !== exp_a) begin n_err++; $display("FAIL b2b_ret1 cyc=%0d got=%h want=%h", cyc, obs_a, exp_a); end
      n_vec++;
      if (obs_b !== exp_b) begin n_err++; $display("FAIL b2b_ret3 cyc=%0d got=%h want=%h", cyc, obs_b, exp_b); end
      n_vec++;
      if (b_v0 !== (i >= 4 && i <= 7) || b_v1 !== 1'b0) begin
        n_err++; $display("FAIL b2b_valid i=%0d got=%b%b want=%b0", i, b_v0, b_v1, (i >= 4 && i <= 7));
      end
      if (i >= 4 && i <= 7) begin
        n_vec++;
        if (b_d0 !== mem((i % 2 == 0) ? 16'h0010 : 16'h0020)) begin
          n_err++; $display("FAIL b2b_data i=%0d got=%h want=%h", i, b_d0, mem((i % 2 == 0) ? 16'h0010 : 16'h0020));
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 10; i++) begin
      drive((i != 1), 1'b0, (i == 0), 16'h0077, (i == 3), 16'h0099);
      n_vec++;
      if (obs_ctl !== exp_ctl) begin n_err++; $display("FAIL midrst_ctl cyc=%0d got=%h want=%h", cyc, obs_ctl, exp_ctl); end
      n_vec++;
      if (obs_a !== exp_a) begin n_err++; $display("FAIL midrst_ret1 cyc=%0d got=%h want=%h", cyc, obs_a, exp_a); end
      n_vec++;
      if (obs_b !== exp_b) begin n_err++; $display("FAIL midrst_ret3 cyc=%0d got=%h want=%h", cyc, obs_b, exp_b); end
      n_vec++;
      if (a_v0 !== 1'b0 && i >= 1 || b_v0 !== 1'b0 && i >= 1 || a_v1 !== (i == 5) || b_v1 !== (i == 7)) begin
        n_err++; $display("FAIL midrst_valid i=%0d got a=%b%b b=%b%b", i, a_v0, a_v1, b_v0, b_v1);
      end
    end
  endtask

  task automatic test_random();
    logic p, r0, r1, rn;
    logic [15:0] x0, x1;
    p = 1'b0; x0 = '0; x1 = '0;
    for (int i = 0; i < 400; i++) begin
      rn = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 19) == 0) p = ~p;
      // A refused requester keeps its address; otherwise pick a fresh one.
      if (!(Req0 && !e_g0)) x0 = 16'($urandom);
      if (!(Req1 && !e_g1)) x1 = 16'($urandom);
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      drive(rn, p, r0, x0, r1, x1);
      n_vec++;
      if (obs_ctl !== exp_ctl) begin n_err++; $display("FAIL rand_ctl cyc=%0d got=%h want=%h", cyc, obs_ctl, exp_ctl); end
      n_vec++;
      if (obs_a !== exp_a) begin n_err++; $display("FAIL rand_ret1 cyc=%0d got=%h want=%h", cyc, obs_a, exp_a); end
      n_vec++;
      if (obs_b !== exp_b) begin n_err++; $display("FAIL rand_ret3 cyc=%0d got=%h want=%h", cyc, obs_b, exp_b); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_strict_guard();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
